// File: rtl/dual_rail_pkg.sv
// Shared definitions for the dual-rail sink merger.
//   - flit type codes carried in the top FLIT_TYPE_WIDTH bits of a flit
//   - merger FSM state encoding and the head-presence classifier
//   - default flit geometry
package dual_rail_pkg;

    localparam int FLIT_DATA_WIDTH_DEF = 32;
    localparam int FLIT_TYPE_WIDTH_DEF = 2;
    localparam int FLIT_WIDTH_DEF      = FLIT_DATA_WIDTH_DEF + FLIT_TYPE_WIDTH_DEF;

    typedef enum logic [1:0] {
        HEADER  = 2'b00,
        PAYLOAD = 2'b01,
        LAST    = 2'b10,
        SINGLE  = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ALIGNED = 2'b01,
        WAIT_A  = 2'b10,
        WAIT_B  = 2'b11
    } merger_state_e;

    // Maps which rail FIFOs hold a head onto the merger state.
    function automatic merger_state_e head_state(input logic a_present, input logic b_present);
        merger_state_e st;
        case ({a_present, b_present})
            2'b11:   st = ALIGNED;
            2'b10:   st = WAIT_B;
            2'b01:   st = WAIT_A;
            default: st = IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/flit_sync_fifo.sv
// Single-clock flit FIFO, one per rail.
//   clk, rst       clock, async active-high reset
//   push/push_data write request and data (ignored while full)
//   pop            read request (ignored while empty)
//   head_data      current head entry
//   full/empty     decoded from the registered count
//   nonempty_nxt   whether a head will be present after this edge
// Full is taken from the registered count only, so a pop and a push in
// the same cycle while full does not let the push through.
module flit_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic             nonempty_nxt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    assign nonempty_nxt = (count_nxt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dual_rail_sink_merger.sv
// Merges the primary (A) and redundant (B) router sink rails into one
// verified flit stream for the sink FSM.
//   clk, reset_globle          clock, async active-high reset
//   flit_sink/valid_sink/ready_sink        primary rail input
//   flit_sink_r/valid_sink_r/ready_sink_r  redundant rail input
//   flit_out/valid_out/ready_out           merged output (registered)
//   degraded_out               flit_out was forwarded single-rail
//   mismatch_pulse/timeout_pulse  one-cycle event strobes, aligned to the load
//   mismatch_cnt/timeout_cnt   saturating event counters
//
// state   | meaning
// IDLE    | neither rail holds a head
// ALIGNED | both rails hold a head; compare and forward
// WAIT_A  | only B holds a head; waiting for rail A
// WAIT_B  | only A holds a head; waiting for rail B
module dual_rail_sink_merger
    import dual_rail_pkg::*;
#(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int FLIT_WIDTH      = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH,
    parameter int FIFO_DEPTH      = 4,
    parameter int SKEW_MAX        = 8,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  reset_globle,
    input  logic [FLIT_WIDTH-1:0] flit_sink,
    input  logic                  valid_sink,
    output logic                  ready_sink,
    input  logic [FLIT_WIDTH-1:0] flit_sink_r,
    input  logic                  valid_sink_r,
    output logic                  ready_sink_r,
    output logic [FLIT_WIDTH-1:0] flit_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  degraded_out,
    output logic                  mismatch_pulse,
    output logic                  timeout_pulse,
    output logic [CNT_WIDTH-1:0]  mismatch_cnt,
    output logic [CNT_WIDTH-1:0]  timeout_cnt
);

    localparam int SW = $clog2(SKEW_MAX + 1);
    localparam int DW = $clog2(FIFO_DEPTH + 1);
    localparam logic [SW-1:0] SKEW_LAST = SW'(SKEW_MAX - 1);
    localparam logic [DW-1:0] DROP_SAT  = DW'(FIFO_DEPTH);

    logic                  rst;
    logic [FLIT_WIDTH-1:0] head_a_data;
    logic [FLIT_WIDTH-1:0] head_b_data;
    logic                  full_a, full_b;
    logic                  empty_a, empty_b;
    logic                  a_nxt, b_nxt;
    logic                  pop_a, pop_b;

    merger_state_e         state_q, state_nxt;
    logic [SW-1:0]         skew_q, skew_nxt;
    logic [DW-1:0]         drop_a_q, drop_a_nxt;
    logic [DW-1:0]         drop_b_q, drop_b_nxt;

    logic                  load_slot;
    logic                  emit;
    logic [FLIT_WIDTH-1:0] emit_flit;
    logic                  emit_deg;
    logic                  mis_set;
    logic                  tmo_set;
    logic                  drop_pend_a, drop_pend_b;

    assign rst          = reset_globle;
    assign ready_sink   = !full_a;
    assign ready_sink_r = !full_b;

    flit_sync_fifo #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_a (
        .clk          (clk),
        .rst          (rst),
        .push         (valid_sink),
        .push_data    (flit_sink),
        .pop          (pop_a),
        .head_data    (head_a_data),
        .full         (full_a),
        .empty        (empty_a),
        .nonempty_nxt (a_nxt)
    );

    flit_sync_fifo #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_b (
        .clk          (clk),
        .rst          (rst),
        .push         (valid_sink_r),
        .push_data    (flit_sink_r),
        .pop          (pop_b),
        .head_data    (head_b_data),
        .full         (full_b),
        .empty        (empty_b),
        .nonempty_nxt (b_nxt)
    );

    // A slot only exists when the output register can take a new flit;
    // nothing (including skew) advances while the sink FSM stalls us.
    assign load_slot   = !valid_out || ready_out;
    assign drop_pend_a = (drop_a_q != '0) && !empty_a;
    assign drop_pend_b = (drop_b_q != '0) && !empty_b;

    // Next state tracks head presence after this edge's pushes and pops.
    assign state_nxt = head_state(a_nxt, b_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            skew_q   <= '0;
            drop_a_q <= '0;
            drop_b_q <= '0;
        end else begin
            state_q  <= state_nxt;
            skew_q   <= skew_nxt;
            drop_a_q <= drop_a_nxt;
            drop_b_q <= drop_b_nxt;
        end
    end

    always_comb begin
        pop_a      = 1'b0;
        pop_b      = 1'b0;
        emit       = 1'b0;
        emit_flit  = head_a_data;
        emit_deg   = 1'b0;
        mis_set    = 1'b0;
        tmo_set    = 1'b0;
        skew_nxt   = skew_q;
        drop_a_nxt = drop_a_q;
        drop_b_nxt = drop_b_q;

        if (load_slot) begin
            // Late partners of flits already forwarded on a timeout are
            // discarded before anything else is considered.
            if (drop_pend_a || drop_pend_b) begin
                if (drop_pend_a) begin
                    pop_a      = 1'b1;
                    drop_a_nxt = drop_a_q - 1'b1;
                end
                if (drop_pend_b) begin
                    pop_b      = 1'b1;
                    drop_b_nxt = drop_b_q - 1'b1;
                end
            end else begin
                unique case (state_q)
                    ALIGNED: begin
                        pop_a     = 1'b1;
                        pop_b     = 1'b1;
                        emit      = 1'b1;
                        emit_flit = head_a_data;
                        emit_deg  = (head_a_data != head_b_data);
                        mis_set   = (head_a_data != head_b_data);
                        skew_nxt  = '0;
                    end
                    WAIT_A: begin
                        if (skew_q == SKEW_LAST) begin
                            pop_b     = 1'b1;
                            emit      = 1'b1;
                            emit_flit = head_b_data;
                            emit_deg  = 1'b1;
                            tmo_set   = 1'b1;
                            skew_nxt  = '0;
                            if (drop_a_q != DROP_SAT) drop_a_nxt = drop_a_q + 1'b1;
                        end else begin
                            skew_nxt = skew_q + 1'b1;
                        end
                    end
                    WAIT_B: begin
                        if (skew_q == SKEW_LAST) begin
                            pop_a     = 1'b1;
                            emit      = 1'b1;
                            emit_flit = head_a_data;
                            emit_deg  = 1'b1;
                            tmo_set   = 1'b1;
                            skew_nxt  = '0;
                            if (drop_b_q != DROP_SAT) drop_b_nxt = drop_b_q + 1'b1;
                        end else begin
                            skew_nxt = skew_q + 1'b1;
                        end
                    end
                    default: begin
                        skew_nxt = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_out       <= '0;
            valid_out      <= 1'b0;
            degraded_out   <= 1'b0;
            mismatch_pulse <= 1'b0;
            timeout_pulse  <= 1'b0;
        end else begin
            mismatch_pulse <= mis_set;
            timeout_pulse  <= tmo_set;
            if (load_slot) begin
                valid_out    <= emit;
                degraded_out <= emit && emit_deg;
                if (emit) flit_out <= emit_flit;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_cnt <= '0;
            timeout_cnt  <= '0;
        end else begin
            if (mis_set && (mismatch_cnt != '1)) mismatch_cnt <= mismatch_cnt + 1'b1;
            if (tmo_set && (timeout_cnt != '1))  timeout_cnt  <= timeout_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dual_rail_sink_merger.sv
module tb_dual_rail_sink_merger;
    import dual_rail_pkg::*;

    localparam int FW    = 34;
    localparam int DEPTH = 4;
    localparam int SKEW  = 8;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          reset_globle;
    logic [FW-1:0] flit_sink, flit_sink_r, flit_out;
    logic          valid_sink, valid_sink_r, ready_sink, ready_sink_r;
    logic          valid_out, ready_out, degraded_out;
    logic          mismatch_pulse, timeout_pulse;
    logic [CW-1:0] mismatch_cnt, timeout_cnt;

    typedef struct {
        logic [FW-1:0] flit;
        logic          deg;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   mis_seen = 0;
    int   tmo_seen = 0;
    bit   mon_en = 1'b1;

    dual_rail_sink_merger #(
        .FLIT_DATA_WIDTH (32),
        .FLIT_TYPE_WIDTH (2),
        .FIFO_DEPTH      (DEPTH),
        .SKEW_MAX        (SKEW),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk            (clk),
        .reset_globle   (reset_globle),
        .flit_sink      (flit_sink),
        .valid_sink     (valid_sink),
        .ready_sink     (ready_sink),
        .flit_sink_r    (flit_sink_r),
        .valid_sink_r   (valid_sink_r),
        .ready_sink_r   (ready_sink_r),
        .flit_out       (flit_out),
        .valid_out      (valid_out),
        .ready_out      (ready_out),
        .degraded_out   (degraded_out),
        .mismatch_pulse (mismatch_pulse),
        .timeout_pulse  (timeout_pulse),
        .mismatch_cnt   (mismatch_cnt),
        .timeout_cnt    (timeout_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: every output transfer is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset_globle && mon_en) begin
            if (mismatch_pulse) mis_seen++;
            if (timeout_pulse)  tmo_seen++;
            if (valid_out && ready_out) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output got=%h deg=%0b required=none", flit_out, degraded_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (flit_out !== e.flit || degraded_out !== e.deg) begin
                        n_err++;
                        $display("FAIL output_flit got=%h deg=%0b required=%h deg=%0b",
                                 flit_out, degraded_out, e.flit, e.deg);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [FW-1:0] mk_flit(input int i, input int n, input logic [31:0] base);
        logic [1:0] t;
        if (n == 1)           t = 2'(SINGLE);
        else if (i == 0)      t = 2'(HEADER);
        else if (i == n - 1)  t = 2'(LAST);
        else                  t = 2'(PAYLOAD);
        return {t, base + 32'(i)};
    endfunction

    task automatic push_a(input logic [FW-1:0] f);
        logic acc;
        int   guard;
        acc = 1'b0;
        guard = 0;
        flit_sink = f;
        valid_sink = 1'b1;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = ready_sink;
            @(posedge clk);
            #1;
            guard++;
        end
        valid_sink = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_a_bound accepted=0 required=1");
        end
    endtask

    task automatic push_b(input logic [FW-1:0] f);
        logic acc;
        int   guard;
        acc = 1'b0;
        guard = 0;
        flit_sink_r = f;
        valid_sink_r = 1'b1;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = ready_sink_r;
            @(posedge clk);
            #1;
            guard++;
        end
        valid_sink_r = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_b_bound accepted=0 required=1");
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_globle = 1'b1;
        valid_sink = 1'b0;
        valid_sink_r = 1'b0;
        flit_sink = '0;
        flit_sink_r = '0;
        ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (valid_out !== 1'b0 || flit_out !== '0 || degraded_out !== 1'b0) begin
            n_err++; $display("FAIL reset_outputs got v=%0b f=%h d=%0b required 0", valid_out, flit_out, degraded_out);
        end
        n_cmp++; if (ready_sink !== 1'b1 || ready_sink_r !== 1'b1) begin
            n_err++; $display("FAIL reset_ready got %0b%0b required 11", ready_sink, ready_sink_r);
        end
        n_cmp++; if (mismatch_cnt !== '0 || timeout_cnt !== '0 || mismatch_pulse !== 1'b0 || timeout_pulse !== 1'b0) begin
            n_err++; $display("FAIL reset_counters got %0d/%0d required 0/0", mismatch_cnt, timeout_cnt);
        end
        reset_globle = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_identical();
        logic [FW-1:0] f;
        int lat, m0, t0;
        f = 34'h0_DEADBEEF;
        m0 = mis_seen;
        t0 = tmo_seen;
        exp_q.push_back('{f, 1'b0});
        fork
            push_a(f);
            push_b(f);
        join
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            if (valid_out) break;
            lat++;
        end
        n_cmp++; if (lat !== 1) begin
            n_err++; $display("FAIL identical_latency got=%0d required=1", lat);
        end
        n_cmp++; if (flit_out !== f || degraded_out !== 1'b0) begin
            n_err++; $display("FAIL identical_flit got=%h d=%0b required=%h d=0", flit_out, degraded_out, f);
        end
        wait_drain();
        n_cmp++; if (exp_q.size() != 0 || mis_seen != m0 || tmo_seen != t0) begin
            n_err++; $display("FAIL identical_drain got left=%0d pulses=%0d/%0d required 0/0/0",
                              exp_q.size(), mis_seen - m0, tmo_seen - t0);
        end
    endtask

    task automatic test_skew(input int d, input int n);
        int m0, t0;
        logic [CW-1:0] mc0, tc0;
        m0 = mis_seen;
        t0 = tmo_seen;
        mc0 = mismatch_cnt;
        tc0 = timeout_cnt;
        for (int i = 0; i < n; i++) exp_q.push_back('{mk_flit(i, n, 32'hA5000000 + 32'(d << 16)), 1'b0});
        fork
            begin
                for (int i = 0; i < n; i++) push_a(mk_flit(i, n, 32'hA5000000 + 32'(d << 16)));
            end
            begin
                repeat (d) @(posedge clk);
                #1;
                for (int j = 0; j < n; j++) push_b(mk_flit(j, n, 32'hA5000000 + 32'(d << 16)));
            end
        join
        wait_drain();
        n_cmp++; if (exp_q.size() != 0) begin
            n_err++; $display("FAIL skew%0d_delivered got_left=%0d required=0", d, exp_q.size());
        end
        n_cmp++; if (mis_seen != m0 || tmo_seen != t0 || mismatch_cnt !== mc0 || timeout_cnt !== tc0) begin
            n_err++; $display("FAIL skew%0d_no_errors got pulses=%0d/%0d cnt=%0d/%0d required 0/0 %0d/%0d",
                              d, mis_seen - m0, tmo_seen - t0, mismatch_cnt, timeout_cnt, mc0, tc0);
        end
    endtask

    task automatic test_mismatch();
        logic [FW-1:0] fa, fb;
        int m0, t0;
        fa = {2'(PAYLOAD), 32'h11111111};
        fb = {2'(PAYLOAD), 32'h11111110};
        m0 = mis_seen;
        t0 = tmo_seen;
        exp_q.push_back('{fa, 1'b1});
        fork
            push_a(fa);
            push_b(fb);
        join
        wait_drain();
        n_cmp++; if (mis_seen - m0 != 1 || tmo_seen != t0) begin
            n_err++; $display("FAIL mismatch_pulse got=%0d/%0d required=1/0", mis_seen - m0, tmo_seen - t0);
        end
        n_cmp++; if (mismatch_cnt !== 16'd1 || timeout_cnt !== 16'd0) begin
            n_err++; $display("FAIL mismatch_cnt got=%0d/%0d required=1/0", mismatch_cnt, timeout_cnt);
        end
    endtask

    task automatic test_timeout();
        logic [FW-1:0] f, g;
        int lat, t0;
        f = 34'h2_CAFE0001;
        g = {2'(SINGLE), 32'h0BADF00D};
        t0 = tmo_seen;
        exp_q.push_back('{f, 1'b1});
        push_a(f);
        lat = 0;
        while (lat < 30) begin
            @(negedge clk);
            if (valid_out) break;
            lat++;
        end
        n_cmp++; if (lat !== SKEW) begin
            n_err++; $display("FAIL timeout_latency got=%0d required=%0d", lat, SKEW);
        end
        wait_drain();
        n_cmp++; if (tmo_seen - t0 != 1 || timeout_cnt !== 16'd1) begin
            n_err++; $display("FAIL timeout_cnt got pulses=%0d cnt=%0d required 1/1", tmo_seen - t0, timeout_cnt);
        end
        n_cmp++; if (dut.drop_b_q !== 3'd1) begin
            n_err++; $display("FAIL drop_b_armed got=%0d required=1", dut.drop_b_q);
        end
        push_b(f);
        repeat (12) @(posedge clk);
        #1;
        n_cmp++; if (dut.drop_b_q !== 3'd0 || valid_out !== 1'b0) begin
            n_err++; $display("FAIL late_partner_drop got drop=%0d valid=%0b required 0/0", dut.drop_b_q, valid_out);
        end
        exp_q.push_back('{g, 1'b0});
        fork
            push_a(g);
            push_b(g);
        join
        wait_drain();
        n_cmp++; if (exp_q.size() != 0 || timeout_cnt !== 16'd1 || mismatch_cnt !== 16'd1) begin
            n_err++; $display("FAIL after_drop_pair got left=%0d cnt=%0d/%0d required 0 1/1",
                              exp_q.size(), mismatch_cnt, timeout_cnt);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 8;
        int ia, ib, cyc, t0;
        logic ra, rb;
        ia = 0;
        ib = 0;
        t0 = tmo_seen;
        for (int i = 0; i < N; i++) exp_q.push_back('{mk_flit(i, N, 32'h5A5A0000), 1'b0});
        ready_out = 1'b0;
        cyc = 0;
        while (cyc < 100 && (ia < N || ib < N)) begin
            if (cyc == 20) begin
                n_cmp++; if (ia != DEPTH + 1 || ib != DEPTH + 1) begin
                    n_err++; $display("FAIL stall_accepts got=%0d/%0d required=%0d", ia, ib, DEPTH + 1);
                end
                n_cmp++; if (ready_sink !== 1'b0 || ready_sink_r !== 1'b0 || valid_out !== 1'b1) begin
                    n_err++; $display("FAIL stall_ready got rdy=%0b%0b v=%0b required 00 1",
                                      ready_sink, ready_sink_r, valid_out);
                end
                ready_out = 1'b1;
            end
            valid_sink   = (ia < N);
            valid_sink_r = (ib < N);
            flit_sink    = mk_flit(ia, N, 32'h5A5A0000);
            flit_sink_r  = mk_flit(ib, N, 32'h5A5A0000);
            @(negedge clk);
            ra = ready_sink;
            rb = ready_sink_r;
            @(posedge clk);
            if (valid_sink && ra)   ia++;
            if (valid_sink_r && rb) ib++;
            #1;
            cyc++;
        end
        valid_sink = 1'b0;
        valid_sink_r = 1'b0;
        ready_out = 1'b1;
        wait_drain();
        n_cmp++; if (exp_q.size() != 0 || ia != N || ib != N) begin
            n_err++; $display("FAIL stall_delivered got left=%0d sent=%0d/%0d required 0 %0d", exp_q.size(), ia, ib, N);
        end
        n_cmp++; if (tmo_seen != t0 || timeout_cnt !== 16'd1) begin
            n_err++; $display("FAIL stall_no_timeout got=%0d cnt=%0d required 0/1", tmo_seen - t0, timeout_cnt);
        end
    endtask

    task automatic test_reset_mid();
        mon_en = 1'b0;
        ready_out = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_sink   = 1'b1;
            valid_sink_r = 1'b1;
            flit_sink    = mk_flit(i, 6, 32'h77000000);
            flit_sink_r  = mk_flit(i, 6, 32'h77000000);
            @(posedge clk);
            #1;
        end
        n_cmp++; if (valid_out !== 1'b1) begin
            n_err++; $display("FAIL mid_packet_active got=%0b required=1", valid_out);
        end
        #2;
        reset_globle = 1'b1;
        #1;
        n_cmp++; if (valid_out !== 1'b0 || flit_out !== '0 || degraded_out !== 1'b0 ||
                     ready_sink !== 1'b1 || ready_sink_r !== 1'b1) begin
            n_err++; $display("FAIL async_reset_outputs got v=%0b f=%h d=%0b rdy=%0b%0b required 0 0 0 11",
                              valid_out, flit_out, degraded_out, ready_sink, ready_sink_r);
        end
        n_cmp++; if (mismatch_cnt !== '0 || timeout_cnt !== '0) begin
            n_err++; $display("FAIL async_reset_counters got %0d/%0d required 0/0", mismatch_cnt, timeout_cnt);
        end
        valid_sink = 1'b0;
        valid_sink_r = 1'b0;
        @(posedge clk);
        #1;
        reset_globle = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back('{mk_flit(i, 3, 32'h33000000), 1'b0});
        fork
            begin
                for (int i = 0; i < 3; i++) push_a(mk_flit(i, 3, 32'h33000000));
            end
            begin
                for (int j = 0; j < 3; j++) push_b(mk_flit(j, 3, 32'h33000000));
            end
        join
        wait_drain();
        n_cmp++; if (exp_q.size() != 0 || mismatch_cnt !== '0 || timeout_cnt !== '0) begin
            n_err++; $display("FAIL post_reset_packet got left=%0d cnt=%0d/%0d required 0 0/0",
                              exp_q.size(), mismatch_cnt, timeout_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_identical();
        test_skew(3, 16);
        test_skew(SKEW - 1, 1);
        test_mismatch();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
